// File: rtl/regfile_param_clr.sv
// Parametrised register file with optional hard-zero x0, optional write-to-read
// bypass, and a sequential clear engine that zeroes the whole file after reset
// or on request. The core must stall while ready=0.

// One read port: priority mux between mask, zero register, bypass and storage.
module regfile_rd_port #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic            ready,
   input  logic [AW-1:0]   raddr,
   input  logic            we,
   input  logic            clr_req,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] rdata
);

   // Contents are undefined until the first clear finishes, so mask to 0.
   always_comb begin
      rdata = word;
      if (!ready)
         rdata = '0;
      else if (ZERO_REG && raddr == '0)
         rdata = '0;
      else if (BYPASS && we && !clr_req && waddr == raddr)
         rdata = wdata;
   end

endmodule

module regfile_param_clr #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   input  logic                clr_req,
   output logic                ready,
   output logic                wr_err
);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     ptr;
   logic [XLEN-1:0]   mem [NREGS];
   logic              clr_wr;
   logic              wr_go;
   logic              err_nxt;

   // State register; reset forces a fresh clear from register 0.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= CLEAR;
      else
         state <= state_nxt;
   end

   // Next state, storage write strobes and the dropped-write flag.
   always_comb begin
      state_nxt = state;
      clr_wr    = 1'b0;
      wr_go     = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         CLEAR: begin
            clr_wr  = 1'b1;
            err_nxt = we;
            if (ptr == AW'(NREGS - 1))
               state_nxt = IDLE;
         end
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               err_nxt   = we;
            end else if (we && !(ZERO_REG && waddr == '0)) begin
               wr_go = 1'b1;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Clear pointer, ready and wr_err registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr    <= '0;
         ready  <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= err_nxt;
         ready  <= (state_nxt == IDLE);
         if (state == CLEAR)
            ptr <= ptr + AW'(1);
         else if (clr_req)
            ptr <= '0;
      end
   end

   // Storage: clear engine and writeback never collide since they are
   // enabled in different states; nothing is touched during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (clr_wr)
            mem[ptr] <= '0;
         else if (wr_go)
            mem[waddr] <= wdata;
      end
   end

   // Independent read ports.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = raddr[i*AW +: AW];
      regfile_rd_port #(
         .XLEN     (XLEN),
         .AW       (AW),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .ready   (ready),
         .raddr   (ra),
         .we      (we),
         .clr_req (clr_req),
         .waddr   (waddr),
         .wdata   (wdata),
         .word    (mem[ra]),
         .rdata   (rdata[i*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_regfile_param_clr.sv
// Directed bench: two instances share stimulus (3-port with bypass, 1-port
// without bypass); a file-level model is checked on every falling edge and
// hand-computed literals pin the model.
module tb_regfile_param_clr;

   logic        clk = 1'b0;
   logic        rst, we, clr_req;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [14:0] raddr;
   logic [95:0] rdata_a;
   logic [31:0] rdata_b;
   logic        ready_a, ready_b, wr_err_a, wr_err_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_param_clr #(.XLEN(32), .NREGS(32), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
      .rdata(rdata_a), .clr_req(clr_req), .ready(ready_a), .wr_err(wr_err_a));

   regfile_param_clr #(.XLEN(32), .NREGS(32), .NRD(1), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr[4:0]),
      .rdata(rdata_b), .clr_req(clr_req), .ready(ready_b), .wr_err(wr_err_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: whole-file view ----------------
   logic [31:0] m_reg [32];
   bit          m_ready = 1'b0;
   bit          m_err   = 1'b0;
   int          m_left  = 0;
   bit          mvalid  = 1'b0;

   always @(posedge clk) begin
      mvalid = 1'b1;
      if (!rst) begin
         m_left = 32; m_ready = 1'b0; m_err = 1'b0;
      end else if (!m_ready) begin
         m_err  = we;
         m_left = m_left - 1;
         if (m_left == 0) begin
            foreach (m_reg[j]) m_reg[j] = '0;
            m_ready = 1'b1;
         end
      end else if (clr_req) begin
         m_left = 32; m_ready = 1'b0; m_err = we;
      end else begin
         m_err = 1'b0;
         if (we && waddr != 5'd0) m_reg[waddr] = wdata;
      end
   end

   function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
      if (!m_ready)                                  return '0;
      if (ra == 5'd0)                                return '0;
      if (byp && we && !clr_req && waddr == ra)      return wdata;
      return m_reg[ra];
   endfunction

   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_ready_a", 32'(ready_a), 32'(m_ready));
         chk("m_ready_b", 32'(ready_b), 32'(m_ready));
         chk("m_err_a", 32'(wr_err_a), 32'(m_err));
         chk("m_err_b", 32'(wr_err_b), 32'(m_err));
         for (int p = 0; p < 3; p++)
            chk("m_rd_a", rdata_a[p*32 +: 32], exp_rd(1'b1, raddr[p*5 +: 5]));
         chk("m_rd_b", rdata_b, exp_rd(1'b0, raddr[4:0]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0; raddr = '0;
      nxt(); nxt();
      rst = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         nxt(); mid();
         chk("rst_ready", 32'(ready_a), (k == 32) ? 32'd1 : 32'd0);
      end
      for (int r = 0; r < 32; r++) begin
         nxt();
         raddr = {5'(r), 5'(r), 5'(r)};
         mid();
         chk("clr_rd", rdata_a[31:0], 32'h0);
      end

      // write / bypass
      nxt();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd0, 5'd5};
      mid();
      chk("byp_same", rdata_a[31:0], 32'hDEADBEEF);
      chk("nobyp_same", rdata_b, 32'h0);
      nxt(); we = 1'b0; mid();
      chk("wr_next_a", rdata_a[31:0], 32'hDEADBEEF);
      chk("wr_next_b", rdata_b, 32'hDEADBEEF);

      // zero register
      nxt(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = '0;
      mid(); chk("x0_same", rdata_a[31:0], 32'h0);
      nxt(); we = 1'b0; mid();
      chk("x0_a", rdata_a[31:0], 32'h0);
      chk("x0_b", rdata_b, 32'h0);
      chk("x0_err", 32'(wr_err_a), 32'h0);

      // multi-port
      nxt(); we = 1'b1; waddr = 5'd9; wdata = 32'h00000099;
      nxt(); we = 1'b0; raddr = {5'd9, 5'd5, 5'd5};
      mid();
      chk("mp_p0", rdata_a[31:0], 32'hDEADBEEF);
      chk("mp_p1", rdata_a[63:32], 32'hDEADBEEF);
      chk("mp_p2", rdata_a[95:64], 32'h00000099);

      // clear collision, then write during clear edge 10
      nxt(); we = 1'b1; waddr = 5'd7; wdata = 32'h00001234;
      nxt(); clr_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h00000055;
      mid(); chk("coll_pre_ready", 32'(ready_a), 32'h1);
      nxt(); clr_req = 1'b0; we = 1'b0;
      mid();
      chk("coll_err", 32'(wr_err_a), 32'h1);
      chk("coll_ready", 32'(ready_a), 32'h0);
      for (int k = 1; k <= 32; k++) begin
         if (k == 10) begin we = 1'b1; waddr = 5'd12; wdata = 32'hAAAA5555; end
         nxt(); we = 1'b0; mid();
         chk("coll_clr_ready", 32'(ready_a), (k == 32) ? 32'd1 : 32'd0);
         if (k == 1)  chk("coll_err_gone", 32'(wr_err_a), 32'h0);
         if (k == 10) chk("clr_wr_err", 32'(wr_err_b), 32'h1);
      end
      nxt(); raddr = {5'd12, 5'd7, 5'd3}; mid();
      chk("coll_r3", rdata_a[31:0], 32'h0);
      chk("coll_r7", rdata_a[63:32], 32'h0);
      chk("coll_r12", rdata_a[95:64], 32'h0);

      // mid-clear reset at clear edge 20
      nxt(); clr_req = 1'b1;
      nxt(); clr_req = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         nxt(); mid();
         chk("mc_ready", 32'(ready_a), 32'h0);
      end
      rst = 1'b0;
      nxt(); rst = 1'b1; mid();
      chk("mc_rst_ready", 32'(ready_a), 32'h0);
      for (int k = 1; k <= 32; k++) begin
         nxt(); mid();
         chk("mc_rel_ready", 32'(ready_b), (k == 32) ? 32'd1 : 32'd0);
      end

      // bypass-off last check on top register
      nxt(); we = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D; raddr = {5'd0, 5'd0, 5'd31};
      mid();
      chk("top_byp_a", rdata_a[31:0], 32'hCAFEF00D);
      chk("top_old_b", rdata_b, 32'h0);
      nxt(); we = 1'b0; mid();
      chk("top_new_b", rdata_b, 32'hCAFEF00D);

      nxt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
